// File: rtl/fifo_burst_drain.sv
// rtl/fifo_burst_drain.sv - drains the pixel FIFO into SDRAM write bursts through a 2-entry skid buffer
module fifo_burst_drain #(
    parameter int DATA_SIZE       = 16,
    parameter int BURST_LEN       = 4,
    parameter int SDRAM_ADDR_SIZE = 22,
    parameter int FRAME_WORDS     = 76800
) (
    input  logic                       r_clk,
    input  logic                       r_rst,
    input  logic                       frame_start,
    input  logic                       fifo_r_almost_empty,
    input  logic                       fifo_r_empty,
    input  logic [DATA_SIZE-1:0]       fifo_r_data,
    output logic                       fifo_r_en,
    output logic                       burst_req,
    output logic [SDRAM_ADDR_SIZE-1:0] burst_addr,
    input  logic                       burst_grant,
    output logic [DATA_SIZE-1:0]       wr_data,
    output logic                       wr_valid,
    input  logic                       wr_ready,
    output logic                       frame_done,
    output logic                       busy
);
    localparam int CW = $clog2(BURST_LEN + 1);
    localparam logic [CW-1:0] BURST_CNT = CW'(BURST_LEN);
    localparam logic [CW-1:0] LAST_WORD = CW'(BURST_LEN - 1);
    localparam logic [SDRAM_ADDR_SIZE:0] ADDR_STEP = (SDRAM_ADDR_SIZE + 1)'(BURST_LEN);
    localparam logic [SDRAM_ADDR_SIZE:0] FRAME_END = (SDRAM_ADDR_SIZE + 1)'(FRAME_WORDS);

    typedef enum logic [1:0] {IDLE, REQ, STREAM, DONE} state_t;

    state_t                     state_q;
    logic [SDRAM_ADDR_SIZE-1:0] addr_q;
    logic                       start_pend_q;
    logic                       frame_done_q;
    logic [CW-1:0]              rd_cnt_q;
    logic [CW-1:0]              wr_cnt_q;

    logic                       inflight_q;
    logic [DATA_SIZE-1:0]       buf_q [2];
    logic                       head_q;
    logic                       tail_q;
    logic [1:0]                 occ_q;
    logic [1:0]                 occ_d;

    logic                       push;
    logic                       pop;
    logic                       room;
    logic [SDRAM_ADDR_SIZE:0]   addr_inc_d;
    logic                       wrap_d;

    assign push = inflight_q;
    assign pop  = wr_valid & wr_ready;

    // A word leaving this cycle frees its slot, which keeps the stream at one word per cycle.
    assign room = ({1'b0, occ_q} + {2'b0, inflight_q}) < (3'd2 + {2'b0, pop});

    assign fifo_r_en = (state_q == STREAM) & ~fifo_r_empty & (rd_cnt_q < BURST_CNT) & room;

    assign addr_inc_d = {1'b0, addr_q} + ADDR_STEP;
    assign wrap_d     = (addr_inc_d == FRAME_END);

    assign burst_req  = (state_q == REQ);
    assign busy       = (state_q != IDLE);
    assign burst_addr = addr_q;
    assign frame_done = frame_done_q;
    assign wr_valid   = (occ_q != 2'd0);
    assign wr_data    = buf_q[head_q];

    always_comb begin
        occ_d = occ_q;
        case ({push, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            start_pend_q <= 1'b0;
            frame_done_q <= 1'b0;
            rd_cnt_q     <= '0;
            wr_cnt_q     <= '0;
        end else begin
            frame_done_q <= 1'b0;
            if (fifo_r_en) begin
                rd_cnt_q <= rd_cnt_q + CW'(1);
            end
            if (pop) begin
                wr_cnt_q <= wr_cnt_q + CW'(1);
            end
            case (state_q)
                IDLE: begin
                    rd_cnt_q <= '0;
                    wr_cnt_q <= '0;
                    if (frame_start) begin
                        addr_q <= '0;
                    end
                    if (!fifo_r_almost_empty) begin
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (frame_start) begin
                        start_pend_q <= 1'b1;
                    end
                    if (burst_grant) begin
                        state_q <= STREAM;
                    end
                end
                STREAM: begin
                    if (frame_start) begin
                        start_pend_q <= 1'b1;
                    end
                    if (pop && (wr_cnt_q == LAST_WORD)) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q      <= IDLE;
                    start_pend_q <= 1'b0;
                    frame_done_q <= wrap_d;
                    // A pending frame restart overrides the increment but never raises frame_done itself.
                    if (wrap_d || start_pend_q || frame_start) begin
                        addr_q <= '0;
                    end else begin
                        addr_q <= addr_inc_d[SDRAM_ADDR_SIZE-1:0];
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            inflight_q <= 1'b0;
            occ_q      <= 2'd0;
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
        end else begin
            inflight_q <= fifo_r_en;
            occ_q      <= occ_d;
            if (push) begin
                buf_q[tail_q] <= fifo_r_data;
                tail_q        <= ~tail_q;
            end
            if (pop) begin
                head_q <= ~head_q;
            end
        end
    end
endmodule

// File: tb/tb_fifo_burst_drain.sv
// tb/tb_fifo_burst_drain.sv - self-checking bench for fifo_burst_drain with FIFO model and scoreboard
module tb_fifo_burst_drain;
    localparam int BL = 4;
    localparam int FW = 12;
    localparam int AE_POS = 5;

    logic        r_clk = 1'b0;
    logic        r_rst;
    logic        frame_start;
    logic        fifo_r_almost_empty;
    logic        fifo_r_empty;
    logic [15:0] fifo_r_data = 16'h0;
    logic        fifo_r_en;
    logic        burst_req;
    logic [21:0] burst_addr;
    logic        burst_grant;
    logic [15:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic        frame_done;
    logic        busy;

    int checks = 0;
    int errors = 0;

    fifo_burst_drain #(
        .DATA_SIZE(16), .BURST_LEN(BL), .SDRAM_ADDR_SIZE(22), .FRAME_WORDS(FW)
    ) dut (
        .r_clk(r_clk), .r_rst(r_rst), .frame_start(frame_start),
        .fifo_r_almost_empty(fifo_r_almost_empty), .fifo_r_empty(fifo_r_empty),
        .fifo_r_data(fifo_r_data), .fifo_r_en(fifo_r_en), .burst_req(burst_req),
        .burst_addr(burst_addr), .burst_grant(burst_grant), .wr_data(wr_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .frame_done(frame_done), .busy(busy)
    );

    always #5 r_clk = ~r_clk;

    // FIFO model: registered read data, flags from the fill level
    logic [15:0] fmem [0:255];
    int wptr = 0;
    int rptr = 0;
    int next_word = 1;
    logic force_nae = 1'b0;

    assign fifo_r_empty        = (wptr == rptr);
    assign fifo_r_almost_empty = !force_nae && ((wptr - rptr) < AE_POS);

    always @(posedge r_clk) begin
        if (fifo_r_en && (wptr != rptr)) begin
            fifo_r_data <= fmem[rptr % 256];
            rptr        <= rptr + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Controller model: grant on the third REQ cycle, wr_ready either constant or 1,0,0 repeating
    int gcnt = 0;
    int rk = 0;
    logic ready_mode = 1'b0;
    initial begin
        burst_grant = 1'b0;
        wr_ready    = 1'b0;
        forever begin
            @(posedge r_clk); #1;
            burst_grant = 1'b0;
            if (burst_req) begin
                if (gcnt == 2) begin
                    burst_grant = 1'b1;
                    gcnt = 0;
                end else begin
                    gcnt++;
                end
            end else begin
                gcnt = 0;
            end
            wr_ready = ready_mode ? ((rk % 3) == 0) : 1'b1;
            rk++;
        end
    end

    // Transaction-level model and per-cycle compare
    logic [15:0] exp_q [$];
    int   m_addr = 0;
    bit   m_pend = 0;
    bit   zero_next = 0;
    bit   inburst = 0;
    bit   streaming = 0;
    int   rd_in = 0;
    int   hs_in = 0;
    int   cd = 0;
    int   bursts_done = 0;
    int   fd_seen = 0;
    int   cyc = 0;
    int   grant_cyc = 0;
    int   hs_cyc [4];
    logic [15:0] hs_dat [4];
    bit   prev_valid = 0;
    bit   prev_ready = 0;
    logic [15:0] prev_data = 16'h0;
    bit   efd;
    int   raw;

    always @(negedge r_clk) begin
        cyc++;
        if (r_rst) begin
            exp_q.delete();
            m_addr = 0; m_pend = 0; zero_next = 0; inburst = 0; streaming = 0;
            rd_in = 0; hs_in = 0; cd = 0; prev_valid = 0;
        end else begin
            efd = 0;
            if (zero_next) begin
                m_addr = 0;
                zero_next = 0;
            end
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    raw = m_addr + BL;
                    efd = (raw == FW);
                    m_addr = (efd || m_pend) ? 0 : raw;
                    m_pend = 0;
                    inburst = 0;
                    bursts_done++;
                end
            end
            fd_seen += int'(frame_done);
            check("frame_done", 32'(frame_done), 32'(efd));
            check("burst_addr", 32'(burst_addr), 32'(m_addr));
            if (burst_req && !inburst) begin
                inburst = 1; rd_in = 0; hs_in = 0;
            end
            check("busy", 32'(busy), 32'(inburst));
            if (streaming) check("req_drop", 32'(burst_req), 0);
            if (fifo_r_en) begin
                check("rd_legal", 32'(streaming && !fifo_r_empty && (rd_in < BL)), 1);
                if (!fifo_r_empty) exp_q.push_back(fmem[rptr % 256]);
                rd_in++;
            end
            if (prev_valid && !prev_ready) begin
                check("hold_valid", 32'(wr_valid), 1);
                check("hold_data", 32'(wr_data), 32'(prev_data));
            end
            if (wr_valid && wr_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wr_data: got %0h expected no word", wr_data);
                end else begin
                    check("wr_data", 32'(wr_data), 32'(exp_q.pop_front()));
                end
                if (hs_in < 4) begin
                    hs_cyc[hs_in] = cyc;
                    hs_dat[hs_in] = wr_data;
                end
                hs_in++;
                if (hs_in == BL) begin
                    check("reads_per_burst", 32'(rd_in), BL);
                    streaming = 0;
                    cd = 2;
                end
            end
            check("outstanding", 32'((rd_in - hs_in) <= 2), 1);
            if (burst_req && burst_grant) begin
                grant_cyc = cyc;
                streaming = 1;
            end
            if (frame_start) begin
                if (inburst) m_pend = 1;
                else zero_next = 1;
            end
            prev_valid = wr_valid;
            prev_ready = wr_ready;
            prev_data  = wr_data;
        end
    end

    task automatic tick();
        @(posedge r_clk); #1;
    endtask

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) begin
            fmem[wptr % 256] = 16'(next_word);
            wptr++;
            next_word++;
        end
    endtask

    task automatic wait_bursts(input int target, input string name);
        for (int k = 0; k < 300; k++) begin
            if (bursts_done >= target) return;
            tick();
        end
        checks++; errors++;
        $display("FAIL %s: got %0d bursts expected %0d (timeout)", name, bursts_done, target);
    endtask

    task automatic wait_hs(input int n, input string name);
        for (int k = 0; k < 300; k++) begin
            tick();
            if (inburst && hs_in >= n) return;
        end
        checks++; errors++;
        $display("FAIL %s: got %0d words expected %0d (timeout)", name, hs_in, n);
    endtask

    int g_first;

    initial begin
        r_rst = 1'b1;
        frame_start = 1'b0;
        repeat (3) @(posedge r_clk);
        #1 r_rst = 1'b0;
        check("rst_fifo_r_en", 32'(fifo_r_en), 0);
        check("rst_burst_req", 32'(burst_req), 0);
        check("rst_burst_addr", 32'(burst_addr), 0);
        check("rst_wr_valid", 32'(wr_valid), 0);
        check("rst_wr_data", 32'(wr_data), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_busy", 32'(busy), 0);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_req", 32'(burst_req), 0);
            check("idle_rd", 32'(fifo_r_en), 0);
        end

        // burst at address 0, full-rate stream of words 1..4
        push_words(8);
        wait_bursts(1, "burst_a");
        for (int i = 0; i < 4; i++) begin
            check("a_data", 32'(hs_dat[i]), i + 1);
            check("a_back_to_back", hs_cyc[i] - hs_cyc[0], i);
        end
        check("a_first_latency", hs_cyc[0] - grant_cyc, 3);
        check("a_addr", 32'(burst_addr), 4);
        repeat (10) tick();
        check("a_no_second_burst", 32'(burst_req), 0);

        // throttled stream at address 4 with a frame restart mid-burst
        ready_mode = 1'b1;
        push_words(4);
        wait_hs(1, "b_start");
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        wait_bursts(2, "burst_b");
        check("b_last_word", 32'(hs_dat[3]), 8);
        check("b_addr_restart", 32'(burst_addr), 0);
        check("b_no_frame_done", fd_seen, 0);
        ready_mode = 1'b0;

        push_words(4);
        wait_bursts(3, "burst_c");
        check("c_addr", 32'(burst_addr), 4);

        // reset after two words of the burst at address 4
        push_words(4);
        wait_hs(2, "f_two_words");
        r_rst = 1'b1;
        tick();
        r_rst = 1'b0;
        wptr = rptr;
        check("f_wr_valid", 32'(wr_valid), 0);
        check("f_busy", 32'(busy), 0);
        check("f_addr", 32'(burst_addr), 0);
        check("f_rd", 32'(fifo_r_en), 0);

        g_first = next_word;
        push_words(8);
        wait_bursts(4, "burst_g");
        check("g_first_word", 32'(hs_dat[0]), g_first);
        check("g_last_word", 32'(hs_dat[3]), g_first + 3);
        check("g_addr", 32'(burst_addr), 4);

        push_words(4);
        wait_bursts(5, "burst_h");
        check("h_addr", 32'(burst_addr), 8);

        push_words(4);
        wait_bursts(6, "burst_e");
        check("e_addr_wrap", 32'(burst_addr), 0);
        check("e_frame_done_count", fd_seen, 1);
        check("e_frame_done_low", 32'(frame_done), 0);

        // underflow: only two words present when the burst starts
        wptr = rptr;
        push_words(2);
        force_nae = 1'b1;
        wait_hs(0, "u_start");
        force_nae = 1'b0;
        repeat (15) tick();
        check("u_stalled_words", hs_in, 2);
        check("u_wr_valid", 32'(wr_valid), 0);
        check("u_busy", 32'(busy), 1);
        check("u_rd", 32'(fifo_r_en), 0);
        push_words(2);
        wait_bursts(7, "burst_u");
        check("u_addr", 32'(burst_addr), 4);

        repeat (5) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
